// File: rtl/delayed_write_sched.sv
// Round-robin scheduler that commits one delayed write at a time into a shared register.
// Define DELAYED_WRITE_ABORT_COUNT_EN to add the saturating abort_count output.
module delayed_write_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 4,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*CW-1:0]   req_delay,
    input  logic                 cancel,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [DW-1:0]        value,
    output logic                 done,
`ifdef DELAYED_WRITE_ABORT_COUNT_EN
    output logic [7:0]           abort_count,
`endif
    output logic                 aborted
);

    localparam int   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic            r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_value;
    logic [NREQ-1:0] r_grant;
    logic            r_busy;
    logic            r_done;
    logic            r_aborted;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [NREQ-1:0] w_grant_vec;
    logic [DW-1:0]   w_sel_data;
    logic [CW-1:0]   w_sel_delay;

    // Round-robin pick: first requester after r_rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found     = 1'b0;
        w_winner    = {PW{1'b0}};
        w_grant_vec = {NREQ{1'b0}};
        w_sel_data  = {DW{1'b0}};
        w_sel_delay = {CW{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && req[j] && (((int'(r_rr_ptr) + i) % NREQ) == j)) begin
                    w_found        = 1'b1;
                    w_winner       = PW'(j);
                    w_grant_vec[j] = 1'b1;
                    w_sel_data     = req_data[j*DW +: DW];
                    w_sel_delay    = req_delay[j*CW +: CW];
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Accept / count down / commit-or-abort state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= PW'(NREQ - 1);
            r_cnt     <= {CW{1'b0}};
            r_data    <= {DW{1'b0}};
            r_value   <= {DW{1'b0}};
            r_grant   <= {NREQ{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_grant   <= {NREQ{1'b0}};
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_WAIT;
                        r_grant  <= w_grant_vec;
                        r_data   <= w_sel_data;
                        r_cnt    <= w_sel_delay;
                        r_rr_ptr <= w_winner;
                        r_busy   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Cancel wins even when the countdown has reached zero.
                    if (cancel) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_cnt != {CW{1'b0}}) begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_value <= r_data;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DELAYED_WRITE_ABORT_COUNT_EN
    logic [7:0] r_abort_count;

    // Saturating count of cancelled writes; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_abort_count <= 8'd0;
        end else if ((r_state == ST_WAIT) && cancel && (r_abort_count != 8'hFF)) begin
            r_abort_count <= r_abort_count + 8'd1;
        end
    end

    assign abort_count = r_abort_count;
`endif

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign value   = r_value;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_delayed_write_sched.sv
// Directed self-checking bench for delayed_write_sched (NREQ=2, DW=4, CW=4).
module tb_delayed_write_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [7:0] req_data;
    logic [7:0] req_delay;
    logic       cancel;
    logic [1:0] grant;
    logic       busy;
    logic [3:0] value;
    logic       done;
    logic       aborted;
`ifdef DELAYED_WRITE_ABORT_COUNT_EN
    logic [7:0] abort_count;
`endif

    int n_checks;
    int n_errors;

    delayed_write_sched #(.NREQ(2), .DW(4), .CW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .req_delay (req_delay),
        .cancel    (cancel),
        .grant     (grant),
        .busy      (busy),
        .value     (value),
        .done      (done),
`ifdef DELAYED_WRITE_ABORT_COUNT_EN
        .abort_count (abort_count),
`endif
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled on the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req       = 2'b00;
        req_data  = 8'h00;
        req_delay = 8'h00;
        cancel    = 1'b0;
        step();
        step();
        check("rst_value", 32'(value), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        reset = 1'b0;
        step();

        // 1: delay 1 commits two edges after acceptance
        req = 2'b01; req_data = 8'h01; req_delay = 8'h01;
        step();
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_busy_e0", 32'(busy), 32'd1);
        req = 2'b00;
        step();
        check("t1_grant_off", 32'(grant), 32'd0);
        check("t1_busy_e1", 32'(busy), 32'd1);
        check("t1_done_e1", 32'(done), 32'd0);
        check("t1_value_e1", 32'(value), 32'd0);
        step();
        check("t1_value", 32'(value), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_e2", 32'(busy), 32'd0);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: cancel right after grant
        do_reset();
        req = 2'b01; req_data = 8'h05; req_delay = 8'h03;
        step();
        check("t2_grant", 32'(grant), 32'd1);
        req = 2'b00; cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t2_aborted", 32'(aborted), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_done", 32'(done), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_no_done", 32'(done), 32'd0);
            check("t2_aborted_once", 32'(aborted), 32'd0);
        end
        check("t2_value", 32'(value), 32'd0);

        // 3: cancel in the same cycle cnt reaches zero
        req = 2'b10; req_data = 8'h70; req_delay = 8'h20;
        step();
        check("t3_grant", 32'(grant), 32'd2);
        req = 2'b00;
        step();
        step();
        check("t3_busy_pre", 32'(busy), 32'd1);
        cancel = 1'b1;
        step();
        check("t3_aborted", 32'(aborted), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_value", 32'(value), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        step();
        cancel = 1'b0;
        check("t3_idle_cancel", 32'(aborted), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);

        // 4: both requesters, delay 0, round-robin alternation
        for (int rep = 0; rep < 2; rep++) begin
            req = 2'b11; req_data = 8'h93; req_delay = 8'h00;
            step();
            check("t4_grant0", 32'(grant), 32'd1);
            req = 2'b10;
            step();
            check("t4_done0", 32'(done), 32'd1);
            check("t4_value0", 32'(value), 32'd3);
            check("t4_grant_gap", 32'(grant), 32'd0);
            step();
            check("t4_grant1", 32'(grant), 32'd2);
            check("t4_done_gap", 32'(done), 32'd0);
            req = 2'b00;
            step();
            check("t4_done1", 32'(done), 32'd1);
            check("t4_value1", 32'(value), 32'd9);
            step();
        end

        // 5: reset mid-countdown drops the write and restores rr_ptr
        req = 2'b01; req_data = 8'h04; req_delay = 8'h05;
        step();
        check("t5_grant", 32'(grant), 32'd1);
        req = 2'b00;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_value", 32'(value), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_aborted", 32'(aborted), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("t5_no_done", 32'(done), 32'd0);
        end
        req = 2'b11; req_data = 8'h62; req_delay = 8'h00;
        step();
        check("t5_fresh_grant", 32'(grant), 32'd1);
        req = 2'b00;
        step();
        check("t5_fresh_value", 32'(value), 32'd2);

`ifdef DELAYED_WRITE_ABORT_COUNT_EN
        // 6: abort counter saturates
        step();
        check("t6_count_zero", 32'(abort_count), 32'd0);
        for (int k = 0; k < 300; k++) begin
            req = 2'b01; req_data = 8'h01; req_delay = 8'h03;
            step();
            req = 2'b00; cancel = 1'b1;
            step();
            cancel = 1'b0;
            step();
            if (k == 2) check("t6_count_3", 32'(abort_count), 32'd3);
        end
        check("t6_count_sat", 32'(abort_count), 32'd255);
        check("t6_value", 32'(value), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
